sixtyfourbit_sub_seq: RTL and testbench
=======================================

Name: sixtyfourbit_sub_seq

Overview:
Multi-cycle 64-bit subtractor with borrow-in and borrow-out. It is the inverse-direction companion of the 64-bit sliced adder. It computes diff = a - b - bin by processing one SLICE_W-bit slice per clock, rippling the borrow between cycles in a register. It sits behind a valid/ready handshake, so the datapath and any downstream consumer can stall it.

Parameters:
WIDTH, 64, operand and result width; must be an integer multiple of SLICE_W
SLICE_W, 32, bits subtracted per clock; NSLICE = WIDTH/SLICE_W slices per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
in_valid  input  1  operands a, b, bin are valid
in_ready  output  1  block can accept a new operation
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  diff/bout hold a completed result
out_ready  input  1  consumer accepts the result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow; 1 iff a < b + bin (unsigned)

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; in_ready=1; out_valid=0; diff=0; bout=0.
  - Internal operand regs, slice index and borrow reg cleared.
  - Reset mid-operation aborts it; no result is emitted.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a, b; borrow_reg<=bin; idx<=0; go RUN.
  - Operand inputs are ignored at all other times.
- RUN:
  - in_ready=0.
  - Each cycle computes {t, d} = {1'b0, a[idx]} - {1'b0, b[idx]} - borrow_reg, where a[idx] and b[idx] are bits [idx*SLICE_W +: SLICE_W].
  - Writes d into diff[idx slice]; borrow_reg<=t (borrow out of the slice); idx<=idx+1.
  - When idx==NSLICE-1: bout<=t; go DONE.
- DONE:
  - out_valid=1; diff and bout held stable.
  - On out_ready=1: out_valid<=0; go IDLE.
  - No new operation is accepted in the same cycle as the output handshake; in_ready rises the following cycle.
- Latency: accept edge E; out_valid is high after edge E+NSLICE (defaults: 2 clocks). Minimum issue interval is NSLICE+2 clocks.
- diff slices not yet written during RUN hold stale values; diff is only defined while out_valid=1.
- Arithmetic:
  - Unsigned wrap-around modulo 2^WIDTH.
  - bin=1 with a==b gives diff = all ones, bout=1.
  - bin=1 with a=0, b=all ones gives diff=0, bout=1.
- out_ready is ignored unless out_valid=1. in_valid is ignored unless state==IDLE.

Optional Feature:
Macro SUB_OVERFLOW_EN.
- Defined: adds output port ovf (1 bit), meaning signed two's-complement overflow.
  - Computed in the last RUN cycle: ovf = (a[W-1]!=b[W-1]) && (diff[W-1]!=a[W-1]), using the MSB of the final slice result.
  - Registered alongside bout and valid with out_valid.
  - Reset value 0; cleared on reset.
- Undefined: port absent, no overflow logic.

Test Plan:
- Reset low 2 cycles, then release -> in_ready=1, out_valid=0, diff=0, bout=0.
- a=5, b=3, bin=0, accept -> out_valid after 2 clocks; diff=2, bout=0.
- a=0, b=1, bin=0 -> diff=64'hFFFF_FFFF_FFFF_FFFF, bout=1.
- Cross-slice borrow: a=64'h0000_0001_0000_0000, b=1, bin=0 -> diff=64'h0000_0000_FFFF_FFFF, bout=0.
- Borrow-in and backpressure: a=b=64'h1234_5678_9ABC_DEF0, bin=1, out_ready low 5 cycles -> out_valid stays 1 with diff=all ones, bout=1, in_ready=0. Raise out_ready -> out_valid 0 next cycle, in_ready 1 the cycle after. Second op a=10, b=4 -> diff=6.
- Reset mid-RUN (one clock after accept) -> next cycle IDLE, in_ready=1, out_valid never asserts.
- With SUB_OVERFLOW_EN:
  - a=64'h8000_0000_0000_0000, b=1 -> diff=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
  - a=5, b=3 -> ovf=0.

Source files
------------

// File: rtl/sixtyfourbit_sub_seq.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b - bin), one SLICE_W slice per clock, valid/ready on both sides.
// Optional signed-overflow output ovf is built when SUB_OVERFLOW_EN is defined.
module sixtyfourbit_sub_seq #(
    parameter int WIDTH   = 64,
    parameter int SLICE_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic [WIDTH-1:0]   diff_reg, diff_next;
    logic               borrow_reg, borrow_next;
    logic               bout_reg, bout_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;

    logic [SLICE_W-1:0] a_slice [NSLICE];
    logic [SLICE_W-1:0] b_slice [NSLICE];
    logic [SLICE_W-1:0] a_sel;
    logic [SLICE_W-1:0] b_sel;
    logic [SLICE_W:0]   slice_res;
    logic               slice_borrow;
    logic               last_slice;
    logic               run_active;

    assign run_active = (state_reg == RUN);

    // Slice views of the latched operands, and per-slice write-back of the result
    generate
        for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
            assign a_slice[gi] = a_reg[gi*SLICE_W +: SLICE_W];
            assign b_slice[gi] = b_reg[gi*SLICE_W +: SLICE_W];
            assign diff_next[gi*SLICE_W +: SLICE_W] =
                (run_active && (idx_reg == IDX_W'(gi))) ? slice_res[SLICE_W-1:0]
                                                        : diff_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    assign a_sel        = a_slice[idx_reg];
    assign b_sel        = b_slice[idx_reg];
    // One extra MSB captures the borrow out of the slice as the sign of the result
    assign slice_res    = {1'b0, a_sel} - {1'b0, b_sel} - {{SLICE_W{1'b0}}, borrow_reg};
    assign slice_borrow = slice_res[SLICE_W];
    assign last_slice   = (idx_reg == IDX_W'(NSLICE - 1));

`ifdef SUB_OVERFLOW_EN
    logic ovf_reg, ovf_next;

    always_comb begin
        ovf_next = ovf_reg;
        if (run_active && last_slice) begin
            ovf_next = (a_reg[WIDTH-1] != b_reg[WIDTH-1]) &&
                       (slice_res[SLICE_W-1] != a_reg[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`endif

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        borrow_next = borrow_reg;
        bout_next   = bout_reg;
        idx_next    = idx_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next      = a;
                    b_next      = b;
                    borrow_next = bin;
                    idx_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                borrow_next = slice_borrow;
                idx_next    = idx_reg + IDX_W'(1);
                if (last_slice) begin
                    bout_next  = slice_borrow;
                    idx_next   = '0;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE first keeps in_ready low for the handshake cycle
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            bout_reg   <= 1'b0;
            idx_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            bout_reg   <= bout_next;
            idx_reg    <= idx_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign bout      = bout_reg;

endmodule

// File: tb/tb_sixtyfourbit_sub_seq.sv
// Randomized self-checking bench for sixtyfourbit_sub_seq against a plain-arithmetic reference.
module tb_sixtyfourbit_sub_seq;

    localparam int WIDTH   = 64;
    localparam int SLICE_W = 32;
    localparam int NSLICE  = WIDTH / SLICE_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SUB_OVERFLOW_EN
    logic             ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sixtyfourbit_sub_seq #(.WIDTH(WIDTH), .SLICE_W(SLICE_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Reference: whole-word unsigned arithmetic
    function automatic logic [WIDTH-1:0] ref_diff(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic [WIDTH:0] w;
        w = {1'b0, x} - {1'b0, y} - (WIDTH+1)'(c);
        return w[WIDTH-1:0];
    endfunction

    function automatic logic ref_bout(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        return ({1'b0, x} < ({1'b0, y} + (WIDTH+1)'(c)));
    endfunction

`ifdef SUB_OVERFLOW_EN
    // True signed result out of the signed WIDTH-bit range means overflow
    function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic signed [WIDTH+1:0] s;
        s = $signed({{2{x[WIDTH-1]}}, x}) - $signed({{2{y[WIDTH-1]}}, y}) - $signed({{(WIDTH+1){1'b0}}, c});
        return (s[WIDTH+1:WIDTH-1] != {3{s[WIDTH-1]}});
    endfunction
`endif

    function automatic logic [WIDTH-1:0] rand_operand();
        logic [WIDTH-1:0] v;
        case ($urandom_range(0, 5))
            0: v = '0;
            1: v = '1;
            2: v = {32'd0, $urandom};
            3: v = {{(WIDTH-1){1'b0}}, 1'b1} << $urandom_range(0, WIDTH-1);
            4: v = {$urandom, 32'hFFFF_FFFF};
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    // Drives one operation and reports what the DUT produced; flow_ok drops if handshakes misbehave
    task automatic do_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b, input logic op_bin,
                         input int hold, output logic [WIDTH-1:0] got_diff, output logic got_bout,
                         output logic got_ovf, output int lat, output bit flow_ok);
        int w;
        flow_ok = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (in_ready !== 1'b1) flow_ok = 1'b0;
        a = op_a; b = op_b; bin = op_bin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = $urandom_range(0, 1);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        got_diff = diff;
        got_bout = bout;
`ifdef SUB_OVERFLOW_EN
        got_ovf = ovf;
`else
        got_ovf = 1'b0;
`endif
        repeat (hold) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || diff !== got_diff || bout !== got_bout || in_ready !== 1'b0) flow_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) flow_ok = 1'b0;
        $display("op a=%h b=%h bin=%0d -> diff=%h bout=%0d ovf=%0d lat=%0d hold=%0d",
                 op_a, op_b, op_bin, got_diff, got_bout, got_ovf, lat, hold);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++; if (diff !== '0) begin n_fail++; $display("FAIL reset_diff got=%h want=0", diff); end
        n_cmp++; if (bout !== 1'b0) begin n_fail++; $display("FAIL reset_bout got=%b want=0", bout); end
`ifdef SUB_OVERFLOW_EN
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
    endtask

    task automatic test_directed();
        logic [WIDTH-1:0] va [5];
        logic [WIDTH-1:0] vb [5];
        logic             vc [5];
        logic [WIDTH-1:0] d;
        logic bo, ov;
        int lat;
        bit fl;
        va[0] = 64'd5;                  vb[0] = 64'd3;  vc[0] = 1'b0;
        va[1] = 64'd0;                  vb[1] = 64'd1;  vc[1] = 1'b0;
        va[2] = 64'h0000_0001_0000_0000; vb[2] = 64'd1; vc[2] = 1'b0;
        va[3] = 64'd0;                  vb[3] = '1;     vc[3] = 1'b1;
        va[4] = '1;                     vb[4] = '1;     vc[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], 0, d, bo, ov, lat, fl);
            n_cmp++; if (d !== ref_diff(va[i], vb[i], vc[i])) begin n_fail++; $display("FAIL directed_diff[%0d] got=%h want=%h", i, d, ref_diff(va[i], vb[i], vc[i])); end
            n_cmp++; if (bo !== ref_bout(va[i], vb[i], vc[i])) begin n_fail++; $display("FAIL directed_bout[%0d] got=%b want=%b", i, bo, ref_bout(va[i], vb[i], vc[i])); end
            n_cmp++; if (lat != NSLICE) begin n_fail++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, NSLICE); end
            n_cmp++; if (!fl) begin n_fail++; $display("FAIL directed_flow[%0d] got=0 want=1", i); end
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] d;
        logic bo, ov;
        int lat;
        bit fl;
        do_op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 5, d, bo, ov, lat, fl);
        n_cmp++; if (d !== {WIDTH{1'b1}}) begin n_fail++; $display("FAIL bp_diff got=%h want=all ones", d); end
        n_cmp++; if (bo !== 1'b1) begin n_fail++; $display("FAIL bp_bout got=%b want=1", bo); end
        n_cmp++; if (!fl) begin n_fail++; $display("FAIL bp_hold_flow got=0 want=1"); end
        do_op(64'd10, 64'd4, 1'b0, 0, d, bo, ov, lat, fl);
        n_cmp++; if (d !== 64'd6) begin n_fail++; $display("FAIL bp_second_diff got=%h want=6", d); end
        n_cmp++; if (bo !== 1'b0) begin n_fail++; $display("FAIL bp_second_bout got=%b want=0", bo); end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 64'd100; b = 64'd7; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (diff !== '0) begin n_fail++; $display("FAIL midrst_diff got=%h want=0", diff); end
        seen = 0;
        repeat (6) begin
            if (out_valid !== 1'b0) seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL midrst_out_valid cycles_high=%0d want=0", seen); end
        $display("op reset during RUN, out_valid high cycles=%0d", seen);
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] ra, rb, d;
        logic rc, bo, ov;
        int lat;
        bit fl;
        for (int i = 0; i < 30; i++) begin
            ra = rand_operand();
            rb = ($urandom_range(0, 4) == 0) ? ra : rand_operand();
            rc = 1'($urandom_range(0, 1));
            do_op(ra, rb, rc, $urandom_range(0, 3), d, bo, ov, lat, fl);
            n_cmp++; if (d !== ref_diff(ra, rb, rc)) begin n_fail++; $display("FAIL rand_diff[%0d] got=%h want=%h", i, d, ref_diff(ra, rb, rc)); end
            n_cmp++; if (bo !== ref_bout(ra, rb, rc)) begin n_fail++; $display("FAIL rand_bout[%0d] got=%b want=%b", i, bo, ref_bout(ra, rb, rc)); end
            n_cmp++; if (lat != NSLICE || !fl) begin n_fail++; $display("FAIL rand_flow[%0d] lat=%0d flow=%0d want lat=%0d flow=1", i, lat, fl, NSLICE); end
`ifdef SUB_OVERFLOW_EN
            n_cmp++; if (ov !== ref_ovf(ra, rb, rc)) begin n_fail++; $display("FAIL rand_ovf[%0d] got=%b want=%b", i, ov, ref_ovf(ra, rb, rc)); end
`endif
        end
    endtask

    // in_valid and out_ready held high; operands change every cycle and only accepted ones may surface
    task automatic test_back_to_back();
        logic [WIDTH-1:0] qa [$];
        logic [WIDTH-1:0] qb [$];
        logic             qc [$];
        logic [WIDTH-1:0] ea, eb;
        logic ec;
        int last_acc, n_out, cyc;
        last_acc = -1; n_out = 0; cyc = 0;
        out_ready = 1'b1;
        while (cyc < 80 && (cyc < 60 || qa.size() != 0)) begin
            if (out_valid === 1'b1) begin
                n_out++;
                n_cmp++;
                if (qa.size() == 0) begin
                    n_fail++; $display("FAIL b2b_unexpected_result diff=%h", diff);
                end else begin
                    ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                    if (diff !== ref_diff(ea, eb, ec) || bout !== ref_bout(ea, eb, ec)) begin
                        n_fail++;
                        $display("FAIL b2b_result got=%h/%b want=%h/%b", diff, bout, ref_diff(ea, eb, ec), ref_bout(ea, eb, ec));
                    end
                    $display("op b2b a=%h b=%h bin=%0d -> diff=%h bout=%0d", ea, eb, ec, diff, bout);
                end
            end
            in_valid = (cyc < 60);
            a = rand_operand(); b = rand_operand(); bin = 1'($urandom_range(0, 1));
            if (in_valid && in_ready === 1'b1) begin
                qa.push_back(a); qb.push_back(b); qc.push_back(bin);
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc != NSLICE + 2) begin
                        n_fail++; $display("FAIL b2b_interval got=%0d want=%0d", cyc - last_acc, NSLICE + 2);
                    end
                end
                last_acc = cyc;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (qa.size() != 0 || n_out < 10) begin n_fail++; $display("FAIL b2b_drain pending=%0d results=%0d want pending=0 results>=10", qa.size(), n_out); end
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        logic [WIDTH-1:0] d;
        logic bo, ov;
        int lat;
        bit fl;
        do_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1, d, bo, ov, lat, fl);
        n_cmp++; if (d !== 64'h7FFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL ovf_diff got=%h want=7fffffffffffffff", d); end
        n_cmp++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%b want=1", ov); end
        n_cmp++; if (bo !== 1'b0) begin n_fail++; $display("FAIL ovf_bout got=%b want=0", bo); end
        do_op(64'd5, 64'd3, 1'b0, 0, d, bo, ov, lat, fl);
        n_cmp++; if (ov !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got=%b want=0", ov); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
